spi_host_master: RTL and testbench
==================================

SPI_HOST_MASTER -- requirements
Module: spi_host_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in clk cycles, legal range 2..255.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin a transaction.
REQ-005 num_bytes  input  10  byte count, sampled with start.
REQ-006 tx_data  input  8  next byte to transmit.
REQ-007 tx_valid  input  1  tx_data valid.
REQ-008 tx_ready  output  1  master accepts tx_data this cycle.
REQ-009 rx_data  output  8  last byte received on MISO.
REQ-010 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-011 busy  output  1  transaction in progress.
REQ-012 done  output  1  one-cycle pulse at transaction end.
REQ-013 SCK, SS, MOSI  output  1 each  SPI bus to the recognizer; MISO input 1.

Function
REQ-014 SPI mode 0: SCK idles low, MOSI changes only while SCK low, MISO sampled on the clk cycle SCK rises, MSB first.
REQ-015 FSM states IDLE, SETUP, LOAD, SHIFT, HOLD; any other encoding returns to IDLE.
REQ-016 IDLE: start=1 with num_bytes!=0 -> SETUP next cycle; SS=0 and busy=1 from that cycle; count latched.
REQ-017 IDLE: start=1 with num_bytes=0 -> done pulses next cycle, SS never asserted, busy stays 0.
REQ-018 start while busy=1 is ignored; num_bytes changes while busy have no effect.
REQ-019 SETUP lasts exactly CLK_DIV cycles with SCK=0, then LOAD.
REQ-020 LOAD: tx_ready=1; tx_ready=0 in every other state; on tx_valid&tx_ready byte latched, MOSI=bit7 next cycle, enter SHIFT.
REQ-021 LOAD stalls indefinitely while tx_valid=0 with SS=0, SCK=0, MOSI holding last value; no timeout.
REQ-022 SHIFT: per bit, SCK low CLK_DIV cycles then high CLK_DIV cycles; exactly 8 rising edges per byte; MOSI advances to next bit on the cycle SCK falls.
REQ-023 Byte end (falling of 8th SCK): rx_valid pulses one cycle with 8 sampled bits (first sampled = bit7); count decrements.
REQ-024 Count nonzero after decrement -> LOAD in same cycle as rx_valid; count zero -> HOLD.
REQ-025 HOLD: SS stays 0 for CLK_DIV cycles, then SS=1, busy=0, done=1 for one cycle, IDLE.
REQ-026 Counter arithmetic 10-bit unsigned; max transaction 1023 bytes; no wrap permitted (decrement stops at 0).
REQ-027 rx_data holds its value until the next rx_valid.

Reset
REQ-028 n_rst=0 asynchronously forces IDLE, SCK=0, SS=1, MOSI=0, tx_ready=0, rx_data=0, rx_valid=0, busy=0, done=0, count=0.
REQ-029 Reset mid-transaction aborts with no done pulse and no partial rx_valid; SS deasserts within the reset assertion, not on a clock edge.
REQ-030 After n_rst rises, first start is honoured on the first clk edge.

Configuration
REQ-031 Macro SPI_HOST_RX_EN defined: MISO sampling, rx_data and rx_valid operate per REQ-022/023/027.
REQ-032 SPI_HOST_RX_EN undefined: MISO ignored, no receive shift register, rx_data tied 0, rx_valid tied 0; all transmit timing unchanged.

Verification
REQ-033 CLK_DIV=4, start num_bytes=1, tx_data=8'hA5 valid -> MOSI bits 1,0,1,0,0,1,0,1 on 8 SCK rising edges, SCK high 4 cycles each, done once, SS low throughout.
REQ-034 Slave model returns 8'h3C on MISO (RX_EN defined) -> rx_valid one cycle with rx_data=8'h3C; RX_EN undefined -> rx_valid never asserts.
REQ-035 num_bytes=785 (784 pixels + label) with tx_valid dropped 20 cycles every 50th byte -> 6280 SCK edges, SCK frozen low during stalls, exactly 785 rx_valid pulses, one done.
REQ-036 start with num_bytes=0 -> done next cycle, SS stays 1, busy stays 0; start during busy -> count unaffected.
REQ-037 n_rst pulsed low mid-byte 3 of 10 -> SS=1, SCK=0 immediately; no done; new 2-byte transaction then completes normally.

Source files
------------

// File: rtl/spi_host_master.sv
// SPI mode-0 host: streams num_bytes bytes from a ready/valid source onto MOSI, MSB first.
// Define SPI_HOST_RX_EN to also capture MISO into rx_data/rx_valid; otherwise those outputs are tied to 0.
module spi_host_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic [9:0] num_bytes,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic       SCK,
   output logic       SS,
   output logic       MOSI,
   input  logic       MISO
);

   typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state;
   logic [7:0] timer;
   logic [2:0] bit_cnt;
   logic [9:0] count;
   logic [7:0] tx_shift;

`ifdef SPI_HOST_RX_EN
   logic [7:0] rx_shift;
`else
   logic unused_miso;
   assign unused_miso = MISO;
   assign rx_data     = 8'h00;
   assign rx_valid    = 1'b0;
`endif

   // One timer paces SETUP, each SCK half-period in SHIFT, and HOLD.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         timer    <= 8'd0;
         bit_cnt  <= 3'd0;
         count    <= 10'd0;
         tx_shift <= 8'd0;
         tx_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         SCK      <= 1'b0;
         SS       <= 1'b1;
         MOSI     <= 1'b0;
`ifdef SPI_HOST_RX_EN
         rx_shift <= 8'd0;
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef SPI_HOST_RX_EN
         rx_valid <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_bytes != 10'd0) begin
                     state <= SETUP;
                     SS    <= 1'b0;
                     busy  <= 1'b1;
                     count <= num_bytes;
                     timer <= 8'd0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            SETUP: begin
               if (timer == DIV_LAST) begin
                  timer    <= 8'd0;
                  tx_ready <= 1'b1;
                  state    <= LOAD;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            LOAD: begin
               if (tx_valid && tx_ready) begin
                  tx_ready <= 1'b0;
                  MOSI     <= tx_data[7];
                  tx_shift <= {tx_data[6:0], 1'b0};
                  bit_cnt  <= 3'd0;
                  timer    <= 8'd0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (timer != DIV_LAST) begin
                  timer <= timer + 8'd1;
               end else if (!SCK) begin
                  timer <= 8'd0;
                  SCK   <= 1'b1;
`ifdef SPI_HOST_RX_EN
                  rx_shift <= {rx_shift[6:0], MISO};
`endif
               end else begin
                  timer <= 8'd0;
                  SCK   <= 1'b0;
                  if (bit_cnt == 3'd7) begin
`ifdef SPI_HOST_RX_EN
                     rx_data  <= rx_shift;
                     rx_valid <= 1'b1;
`endif
                     count <= (count != 10'd0) ? count - 10'd1 : 10'd0;
                     // count is pre-decrement here, so >1 means bytes remain afterwards
                     if (count > 10'd1) begin
                        tx_ready <= 1'b1;
                        state    <= LOAD;
                     end else begin
                        state <= HOLD;
                     end
                  end else begin
                     bit_cnt  <= bit_cnt + 3'd1;
                     MOSI     <= tx_shift[7];
                     tx_shift <= {tx_shift[6:0], 1'b0};
                  end
               end
            end
            HOLD: begin
               if (timer == DIV_LAST) begin
                  timer <= 8'd0;
                  SS    <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            default: begin
               state    <= IDLE;
               timer    <= 8'd0;
               tx_ready <= 1'b0;
               busy     <= 1'b0;
               SCK      <= 1'b0;
               SS       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_host_master.sv
// Randomized bench for spi_host_master: a slave model drives MISO, monitors log the bus,
// and each transaction is judged against byte lists and timing derived from the bus rules.
module tb_spi_host_master;

   localparam int CLK_DIV = 4;
   localparam int READY_LIMIT = 40 * CLK_DIV;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       start;
   logic [9:0] num_bytes;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       done;
   logic       SCK;
   logic       SS;
   logic       MOSI;
   logic       MISO;

   spi_host_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .num_bytes(num_bytes),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
      .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
      end
   endtask

   logic [7:0] tx_mem  [0:1023];
   logic [7:0] slv_mem [0:1023];

   // Slave presents the next MISO bit after every SCK fall; SS high rewinds it.
   logic [9:0] slv_byte = 10'd0;
   logic [2:0] slv_bit  = 3'd0;
   always @(negedge SCK or posedge SS) begin
      if (SS) begin
         slv_byte <= 10'd0;
         slv_bit  <= 3'd0;
      end else if (slv_bit == 3'd7) begin
         slv_bit  <= 3'd0;
         slv_byte <= slv_byte + 10'd1;
      end else begin
         slv_bit <= slv_bit + 3'd1;
      end
   end
   assign MISO = slv_mem[slv_byte][3'd7 - slv_bit];

   logic       sck_prev = 1'b0;
   logic       mosi_prev = 1'b0;
   logic       rx_prev = 1'b0;
   int         rise_count = 0;
   int         high_len = 0;
   int         bad_high = 0;
   int         mosi_bad = 0;
   int         done_count = 0;
   int         rx_wide = 0;
   int         sck_ss_bad = 0;
   int         ss_low_cycles = 0;
   logic       mosi_log[$];
   logic [7:0] rx_log[$];

   // Bus monitor sampled mid-cycle.
   always @(negedge clk) begin
      if (SCK === 1'b1) begin
         if (sck_prev !== 1'b1) begin
            rise_count <= rise_count + 1;
            mosi_log.push_back(MOSI);
            high_len <= 1;
         end else begin
            high_len <= high_len + 1;
            if (MOSI !== mosi_prev) mosi_bad <= mosi_bad + 1;
         end
         if (SS !== 1'b0) sck_ss_bad <= sck_ss_bad + 1;
      end else if (sck_prev === 1'b1 && high_len != CLK_DIV) begin
         bad_high <= bad_high + 1;
      end
      if (done === 1'b1) done_count <= done_count + 1;
      if (rx_valid === 1'b1) begin
         rx_log.push_back(rx_data);
         if (rx_prev === 1'b1) rx_wide <= rx_wide + 1;
      end
      if (SS === 1'b0) ss_low_cycles <= ss_low_cycles + 1;
      sck_prev  <= SCK;
      mosi_prev <= MOSI;
      rx_prev   <= rx_valid;
   end

   task automatic waitReady(output bit ok);
      int waited = 0;
      while (tx_ready !== 1'b1 && waited < READY_LIMIT) begin
         @(negedge clk);
         waited++;
      end
      ok = (tx_ready === 1'b1);
      if (!ok) checkOutput("tx_ready_timeout", tx_ready, 1);
   endtask

   // Called on a negedge; runs one full transaction of n bytes from tx_mem and checks it.
   task automatic applyStimulus(input int n, input bit stalls, input bit poke);
      int rb = rise_count;
      int mb = mosi_log.size();
      int xb = rx_log.size();
      int db = done_count;
      int hb = bad_high;
      int mbd = mosi_bad;
      int sb = sck_ss_bad;
      int wb = rx_wide;
      int sl = ss_low_cycles;
      int nstalls = 0;
      int stall_bad = 0;
      int ready_bad = 0;
      int mism = 0;
      int waited = 0;
      bit ok = 1'b1;
      start = 1'b1;
      num_bytes = 10'(n);
      @(negedge clk);
      start = 1'b0;
      num_bytes = 10'($urandom);
      checkOutput("busy_after_start", busy, 1);
      checkOutput("ss_after_start", SS, 0);
      for (int k = 0; k < n && ok; k++) begin
         waitReady(ok);
         if (ok) begin
            if (stalls && ((k + 1) % 50 == 0)) begin
               int r0 = rise_count;
               nstalls++;
               tx_valid = 1'b0;
               for (int c = 0; c < 20; c++) begin
                  if (SCK !== 1'b0 || SS !== 1'b0 || tx_ready !== 1'b1) stall_bad++;
                  @(negedge clk);
               end
               if (rise_count != r0) stall_bad++;
            end
            tx_valid = 1'b1;
            tx_data  = tx_mem[k];
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            if (tx_ready !== 1'b0) ready_bad++;
            if (poke && k == 1) begin
               start = 1'b1;
               num_bytes = 10'd7;
               @(negedge clk);
               start = 1'b0;
            end
         end
      end
      while (done !== 1'b1 && waited < READY_LIMIT) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("done_seen", done, 1);
      repeat (3) @(negedge clk);
      checkOutput("sck_rises", rise_count - rb, 8 * n);
      checkOutput("sck_high_len_bad", bad_high - hb, 0);
      checkOutput("mosi_change_while_high", mosi_bad - mbd, 0);
      for (int k = 0; k < n; k++) begin
         logic [7:0] b;
         int idx;
         b = 8'd0;
         for (int i = 0; i < 8; i++) begin
            idx = mb + 8 * k + i;
            b = {b[6:0], (idx < mosi_log.size()) ? mosi_log[idx] : 1'bx};
         end
         if (b !== tx_mem[k]) mism++;
      end
      checkOutput("mosi_bytes_bad", mism, 0);
`ifdef SPI_HOST_RX_EN
      checkOutput("rx_pulses", rx_log.size() - xb, n);
      mism = 0;
      for (int k = 0; k < n; k++)
         if (xb + k >= rx_log.size() || rx_log[xb + k] !== slv_mem[k]) mism++;
      checkOutput("rx_bytes_bad", mism, 0);
`else
      checkOutput("rx_pulses", rx_log.size() - xb, 0);
`endif
      checkOutput("rx_valid_wide", rx_wide - wb, 0);
      checkOutput("done_pulses", done_count - db, 1);
      checkOutput("stall_bad", stall_bad, 0);
      checkOutput("tx_ready_after_accept", ready_bad, 0);
      checkOutput("sck_while_ss_high", sck_ss_bad - sb, 0);
      checkOutput("ss_low_cycles", ss_low_cycles - sl,
                  2 * CLK_DIV + n * (1 + 16 * CLK_DIV) + 20 * nstalls);
      checkOutput("busy_end", busy, 0);
      checkOutput("ss_end", SS, 1);
   endtask

   initial begin
      int db;
      int xr;
      int rb;
      int waited;
      bit ok;
      n_rst = 1'b0;
      start = 1'b0;
      num_bytes = 10'd0;
      tx_data = 8'd0;
      tx_valid = 1'b0;
      for (int i = 0; i < 1024; i++) slv_mem[i] = 8'($urandom);

      #12;
      checkOutput("rst_ss", SS, 1);
      checkOutput("rst_sck", SCK, 0);
      checkOutput("rst_mosi", MOSI, 0);
      checkOutput("rst_tx_ready", tx_ready, 0);
      checkOutput("rst_rx_data", rx_data, 0);
      checkOutput("rst_rx_valid", rx_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] single byte 0xA5 / slave 0x3C");
      tx_mem[0] = 8'hA5;
      slv_mem[0] = 8'h3C;
      applyStimulus(1, 1'b0, 1'b0);

      $display("[TB] zero-length start");
      db = done_count;
      start = 1'b1;
      num_bytes = 10'd0;
      @(negedge clk);
      start = 1'b0;
      checkOutput("zero_done", done, 1);
      checkOutput("zero_ss", SS, 1);
      checkOutput("zero_busy", busy, 0);
      @(negedge clk);
      checkOutput("zero_done_single", done, 0);
      checkOutput("zero_ss_after", SS, 1);
      checkOutput("zero_busy_after", busy, 0);

      $display("[TB] random short transactions");
      for (int t = 0; t < 4; t++) begin
         int n = $urandom_range(2, 6);
         for (int k = 0; k < n; k++) begin
            tx_mem[k] = 8'($urandom);
            slv_mem[k] = 8'($urandom);
         end
         @(negedge clk);
         applyStimulus(n, 1'b0, t[0]);
      end

      $display("[TB] reset during byte 3 of 10");
      for (int k = 0; k < 10; k++) tx_mem[k] = 8'($urandom);
      @(negedge clk);
      db = done_count;
      rb = rise_count;
      start = 1'b1;
      num_bytes = 10'd10;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 3 && ok; k++) begin
         waitReady(ok);
         if (ok) begin
            tx_valid = 1'b1;
            tx_data = tx_mem[k];
            @(negedge clk);
            tx_valid = 1'b0;
         end
      end
      waited = 0;
      while (rise_count < rb + 20 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("reached_byte3", (rise_count >= rb + 20) ? 1 : 0, 1);
      #2;
      n_rst = 1'b0;
      #1;
      checkOutput("abort_ss", SS, 1);
      checkOutput("abort_sck", SCK, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_tx_ready", tx_ready, 0);
      checkOutput("abort_rx_data", rx_data, 0);
      xr = rx_log.size();
      repeat (3) @(negedge clk);
      checkOutput("abort_no_done", done_count - db, 0);
      checkOutput("abort_no_rx", rx_log.size() - xr, 0);
      n_rst = 1'b1;
      tx_mem[0] = 8'($urandom);
      tx_mem[1] = 8'($urandom);
      applyStimulus(2, 1'b0, 1'b0);

      $display("[TB] 785-byte frame with stalls");
      for (int k = 0; k < 785; k++) begin
         tx_mem[k] = 8'($urandom);
         slv_mem[k] = 8'($urandom);
      end
      @(negedge clk);
      applyStimulus(785, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
